// File: rtl/sudoku_pkg.sv
// Shared definitions for the Sudoku game controller, its datapath and benches:
// state encoding, difficulty codes and width helpers.
package sudoku_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd1,
    ST_CLEAR    = 4'd2,
    ST_SET_DIFF = 4'd3,
    ST_PREFILL  = 4'd4,
    ST_PLAY     = 4'd5,
    ST_GUESS    = 4'd6,
    ST_CHECK    = 4'd7,
    ST_FIN      = 4'd8,
    ST_LOST     = 4'd9
  } state_t;

  localparam logic [1:0] DIFF_EASY = 2'd0;
  localparam logic [1:0] DIFF_MED  = 2'd1;
  localparam logic [1:0] DIFF_HARD = 2'd2;

  // Bits needed to index v items; never below 1 so degenerate sizes still elaborate.
  function automatic int clog2w(input int v);
    int w;
    w = 0;
    while ((1 << w) < v) w++;
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int cells_of(input int n);
    return n * n;
  endfunction

endpackage

// File: rtl/sudoku_dp_if.sv
// Command/check handshake between the game controller (master) and the
// board datapath (slave).
interface sudoku_dp_if #(
  parameter int N = 9
);
  localparam int CELLS = sudoku_pkg::cells_of(N);
  localparam int CW    = sudoku_pkg::clog2w(CELLS);
  localparam int RW    = sudoku_pkg::clog2w(N);
  localparam int VW    = sudoku_pkg::clog2w(N + 1);

  logic          cell_we;
  logic          cell_reveal;
  logic [CW-1:0] cell_idx;
  logic [RW-1:0] guess_row;
  logic [RW-1:0] guess_col;
  logic [VW-1:0] guess_val;
  logic          dp_check;
  logic          dp_done;
  logic          dp_ok;
  logic          dp_new;

  modport master (
    output cell_we, cell_reveal, cell_idx, guess_row, guess_col, guess_val, dp_check,
    input  dp_done, dp_ok, dp_new
  );

  modport slave (
    input  cell_we, cell_reveal, cell_idx, guess_row, guess_col, guess_val, dp_check,
    output dp_done, dp_ok, dp_new
  );

endinterface

// File: rtl/sudoku_cell_walker.sv
// Cell index sequencer: steps linearly (board clear) or by a fixed stride
// modulo CELLS (prefill) for a programmed number of cycles.
module sudoku_cell_walker
  import sudoku_pkg::*;
#(
  parameter int CELLS = 81,
  parameter int STEP  = 7,
  parameter int CW    = 7
)(
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stride,
  input  logic [CW:0]   count,
  output logic [CW-1:0] idx,
  output logic          active,
  output logic          done
);

  localparam int STEP_M = STEP % CELLS;

  logic [CW:0] remaining;
  logic        stride_q;
  logic [CW:0] sum;

  // Both operands are below CELLS, so one conditional subtract is a full modulo.
  always_comb begin
    sum = {1'b0, idx} + (stride_q ? (CW+1)'(STEP_M) : (CW+1)'(1));
    if (sum >= (CW+1)'(CELLS)) sum = sum - (CW+1)'(CELLS);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= '0;
      remaining <= '0;
      stride_q  <= 1'b0;
    end else if (start) begin
      idx       <= '0;
      remaining <= count;
      stride_q  <= stride;
    end else if (active) begin
      idx       <= sum[CW-1:0];
      remaining <= remaining - (CW+1)'(1);
    end
  end

  assign active = (remaining != '0);
  assign done   = (remaining == (CW+1)'(1));

endmodule

// File: rtl/sudoku_game_ctrl_p.sv
// Parametrised Sudoku game controller: sequences board clear and prefill,
// runs guesses through the datapath legality check, and tracks the result.
module sudoku_game_ctrl_p
  import sudoku_pkg::*;
#(
  parameter int N           = 9,
  parameter int STEP        = 7,
  parameter int REVEAL_EASY = 45,
  parameter int REVEAL_MED  = 35,
  parameter int REVEAL_HARD = 25,
  parameter int MAX_STRIKES = 3,
  parameter int TIMEOUT     = 15,
  localparam int CELLS      = N * N,
  localparam int CW         = clog2w(CELLS),
  localparam int RW         = clog2w(N),
  localparam int VW         = clog2w(N + 1),
  localparam int SW         = clog2w(MAX_STRIKES + 1)
)(
  input  logic          clka,
  input  logic          restart,
  input  logic          enter,
  input  logic [1:0]    difficulty,
  input  logic [RW-1:0] row_in,
  input  logic [RW-1:0] col_in,
  input  logic [VW-1:0] val_in,
  sudoku_dp_if.master   dp,
  output logic [3:0]    state,
  output logic          won,
  output logic          lost,
  output logic          err,
  output logic [SW-1:0] strikes,
  output logic [CW:0]   filled
);

  localparam int TW = clog2w(TIMEOUT + 1);

  state_t        state_q, state_d;
  logic          enter_q, enter_rise;
  logic [1:0]    lvl_q, lvl_d;
  logic [CW:0]   filled_q, filled_d, filled_inc;
  logic [SW-1:0] strikes_q, strikes_d, strikes_inc;
  logic [RW-1:0] grow_q, gcol_q;
  logic [VW-1:0] gval_q;
  logic          latch_guess, guess_ok;
  logic [TW-1:0] timer_q;
  logic          err_q, err_d;
  logic          w_start, w_stride, w_active, w_done;
  logic [CW:0]   w_count;
  logic [CW-1:0] w_idx;

  function automatic logic [CW:0] reveal_for(input logic [1:0] l);
    case (l)
      DIFF_EASY: reveal_for = (CW+1)'(REVEAL_EASY);
      DIFF_MED:  reveal_for = (CW+1)'(REVEAL_MED);
      default:   reveal_for = (CW+1)'(REVEAL_HARD);
    endcase
  endfunction

  sudoku_cell_walker #(.CELLS(CELLS), .STEP(STEP), .CW(CW)) u_walker (
    .clk    (clka),
    .rst    (restart),
    .start  (w_start),
    .stride (w_stride),
    .count  (w_count),
    .idx    (w_idx),
    .active (w_active),
    .done   (w_done)
  );

  assign enter_rise  = enter & ~enter_q;
  assign filled_inc  = (filled_q < (CW+1)'(CELLS)) ? filled_q + (CW+1)'(1) : filled_q;
  assign strikes_inc = (strikes_q < SW'(MAX_STRIKES)) ? strikes_q + SW'(1) : strikes_q;
  assign guess_ok    = (int'(grow_q) < N) && (int'(gcol_q) < N) &&
                       (gval_q != '0) && (int'(gval_q) <= N);

  // Next-state and counter updates; a dp_done in the timeout cycle takes priority.
  always_comb begin
    state_d     = state_q;
    lvl_d       = lvl_q;
    filled_d    = filled_q;
    strikes_d   = strikes_q;
    err_d       = 1'b0;
    latch_guess = 1'b0;
    w_start     = 1'b0;
    w_stride    = 1'b0;
    w_count     = '0;
    case (state_q)
      ST_IDLE: begin
        if (enter_rise) begin
          state_d = ST_CLEAR;
          w_start = 1'b1;
          w_count = (CW+1)'(CELLS);
        end
      end
      ST_CLEAR: begin
        filled_d  = '0;
        strikes_d = '0;
        if (w_done) state_d = ST_SET_DIFF;
      end
      ST_SET_DIFF: begin
        if (enter_rise) begin
          lvl_d    = (difficulty == 2'd3) ? DIFF_HARD : difficulty;
          state_d  = ST_PREFILL;
          w_start  = 1'b1;
          w_stride = 1'b1;
          w_count  = reveal_for(lvl_d);
        end
      end
      ST_PREFILL: begin
        if (w_active) filled_d = filled_inc;
        if (!w_active || w_done) state_d = ST_PLAY;
      end
      ST_PLAY: begin
        if (enter_rise) begin
          latch_guess = 1'b1;
          state_d     = ST_GUESS;
        end
      end
      ST_GUESS: begin
        if (guess_ok) begin
          state_d = ST_CHECK;
        end else begin
          err_d   = 1'b1;
          state_d = ST_PLAY;
        end
      end
      ST_CHECK: begin
        if (dp.dp_done) begin
          if (dp.dp_ok) begin
            if (dp.dp_new) filled_d = filled_inc;
            state_d = (filled_d == (CW+1)'(CELLS)) ? ST_FIN : ST_PLAY;
          end else begin
            strikes_d = strikes_inc;
            state_d   = (strikes_d == SW'(MAX_STRIKES)) ? ST_LOST : ST_PLAY;
          end
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = ST_PLAY;
        end
      end
      ST_FIN, ST_LOST: begin
        if (enter_rise) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clka) begin
    if (restart) begin
      state_q   <= ST_IDLE;
      enter_q   <= 1'b0;
      lvl_q     <= '0;
      filled_q  <= '0;
      strikes_q <= '0;
      grow_q    <= '0;
      gcol_q    <= '0;
      gval_q    <= '0;
      timer_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      enter_q   <= enter;
      lvl_q     <= lvl_d;
      filled_q  <= filled_d;
      strikes_q <= strikes_d;
      err_q     <= err_d;
      timer_q   <= (state_q == ST_CHECK) ? timer_q + TW'(1) : '0;
      if (latch_guess) begin
        grow_q <= row_in;
        gcol_q <= col_in;
        gval_q <= val_in;
      end
    end
  end

  assign state          = state_q;
  assign won            = (state_q == ST_FIN);
  assign lost           = (state_q == ST_LOST);
  assign err            = err_q;
  assign strikes        = strikes_q;
  assign filled         = filled_q;
  assign dp.cell_we     = (state_q == ST_CLEAR) || ((state_q == ST_PREFILL) && w_active);
  assign dp.cell_reveal = (state_q == ST_PREFILL) && w_active;
  assign dp.cell_idx    = dp.cell_we ? w_idx : '0;
  assign dp.dp_check    = (state_q == ST_CHECK) && (timer_q == '0);
  assign dp.guess_row   = grow_q;
  assign dp.guess_col   = gcol_q;
  assign dp.guess_val   = gval_q;

endmodule

// File: tb/tb_sudoku_game_ctrl_p.sv
// Randomised scoreboard bench for sudoku_game_ctrl_p on a 4x4 board; the bench
// plays the datapath role and predicts outcomes from the game rules.
module tb_sudoku_game_ctrl_p;
  import sudoku_pkg::*;

  localparam int N      = 4;
  localparam int CELLS  = N * N;
  localparam int STEP   = 5;
  localparam int R_EASY = 3;
  localparam int R_MED  = 2;
  localparam int R_HARD = 1;
  localparam int MAXS   = 3;
  localparam int TMO    = 15;
  localparam int RW     = $clog2(N);
  localparam int VW     = $clog2(N + 1);
  localparam int CW     = $clog2(CELLS);
  localparam int SW     = $clog2(MAXS + 1);

  localparam int P_NEW = 0, P_OLD = 1, P_BAD = 2, P_TMO = 3, P_EXP = 4, P_RANGE = 5;

  typedef struct {
    bit reveal;
    int idx;
  } cmd_t;

  typedef struct {
    int st;
    int strikes;
    int filled;
    bit e_err;
    bit chk;
    int row;
    int col;
    int val;
  } status_t;

  logic          clka = 1'b0;
  logic          restart, enter;
  logic [1:0]    difficulty;
  logic [RW-1:0] row_in, col_in;
  logic [VW-1:0] val_in;
  logic [3:0]    state;
  logic          won, lost, err;
  logic [SW-1:0] strikes;
  logic [CW:0]   filled;

  sudoku_dp_if #(.N(N)) dp_if ();

  sudoku_game_ctrl_p #(
    .N(N), .STEP(STEP), .REVEAL_EASY(R_EASY), .REVEAL_MED(R_MED),
    .REVEAL_HARD(R_HARD), .MAX_STRIKES(MAXS), .TIMEOUT(TMO)
  ) dut (
    .clka       (clka),
    .restart    (restart),
    .enter      (enter),
    .difficulty (difficulty),
    .row_in     (row_in),
    .col_in     (col_in),
    .val_in     (val_in),
    .dp         (dp_if),
    .state      (state),
    .won        (won),
    .lost       (lost),
    .err        (err),
    .strikes    (strikes),
    .filled     (filled)
  );

  always #5 clka = ~clka;

  int      errors = 0;
  int      checks = 0;
  cmd_t    cmd_q[$];
  status_t stat_q[$];
  int      m_filled = 0;
  int      m_strikes = 0;
  int      mon_prev = 0;
  bit      saw_chk = 1'b0;

  task automatic report_fail(input string name, input string detail);
    checks++;
    errors++;
    $display("[TB] FAIL %s: %s", name, detail);
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clka);
  endtask

  task automatic wait_state(input int target, input int budget, input string name);
    int k;
    k = 0;
    while (int'(state) != target && k < budget) begin
      @(negedge clka);
      k++;
    end
    checkOutput(name, int'(state), target);
  endtask

  task automatic pulse_enter();
    @(negedge clka);
    enter = 1'b1;
    @(negedge clka);
    enter = 1'b0;
  endtask

  // Expected board commands: a full linear clear, then a stride walk of R reveals.
  task automatic new_game(input int diff, input bit hold, input bit mid_pulse);
    int   r;
    cmd_t c;
    r = (diff == 0) ? R_EASY : (diff == 1) ? R_MED : R_HARD;
    for (int i = 0; i < CELLS; i++) begin
      c.reveal = 1'b0;
      c.idx    = i;
      cmd_q.push_back(c);
    end
    for (int k = 0; k < r; k++) begin
      c.reveal = 1'b1;
      c.idx    = (k * STEP) % CELLS;
      cmd_q.push_back(c);
    end
    if (hold) begin
      @(negedge clka);
      enter = 1'b1;
      tick(CELLS + 6);
      checkOutput("hold_enter_state", int'(state), ST_SET_DIFF);
      enter = 1'b0;
    end else begin
      pulse_enter();
      if (mid_pulse) begin
        tick(4);
        checkOutput("mid_clear_state", int'(state), ST_CLEAR);
        pulse_enter();
      end
      wait_state(ST_SET_DIFF, CELLS + 4, "clear_done");
    end
    checkOutput("clear_filled", int'(filled), 0);
    checkOutput("clear_strikes", int'(strikes), 0);
    tick(2);
    checkOutput("set_diff_wait", int'(state), ST_SET_DIFF);
    @(negedge clka);
    difficulty = 2'(diff);
    enter = 1'b1;
    @(negedge clka);
    enter = 1'b0;
    difficulty = 2'($urandom_range(0, 3));
    wait_state(ST_PLAY, r + 4, "prefill_done");
    m_filled  = r;
    m_strikes = 0;
    checkOutput("prefill_filled", int'(filled), r);
  endtask

  // One guess: predict the outcome from the rules, then act as the datapath.
  task automatic applyStimulus(input int plan);
    status_t s;
    int      k;
    s.row = $urandom_range(0, N - 1);
    s.col = $urandom_range(0, N - 1);
    if (plan == P_RANGE)
      s.val = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(N + 1, (1 << VW) - 1);
    else
      s.val = $urandom_range(1, N);
    s.e_err = 1'b0;
    s.chk   = (plan != P_RANGE);
    s.st    = ST_PLAY;
    case (plan)
      P_RANGE, P_TMO: s.e_err = 1'b1;
      P_NEW, P_EXP: begin
        if (m_filled < CELLS) m_filled++;
        s.st = (m_filled == CELLS) ? ST_FIN : ST_PLAY;
      end
      P_OLD: s.st = (m_filled == CELLS) ? ST_FIN : ST_PLAY;
      P_BAD: begin
        if (m_strikes < MAXS) m_strikes++;
        s.st = (m_strikes == MAXS) ? ST_LOST : ST_PLAY;
      end
      default: ;
    endcase
    s.strikes = m_strikes;
    s.filled  = m_filled;
    stat_q.push_back(s);

    @(negedge clka);
    row_in = RW'(s.row);
    col_in = RW'(s.col);
    val_in = VW'(s.val);
    enter  = 1'b1;
    @(negedge clka);
    enter  = 1'b0;
    row_in = RW'($urandom);
    col_in = RW'($urandom);
    val_in = VW'($urandom);
    if (plan != P_RANGE) begin
      k = 0;
      while (!dp_if.dp_check && k < 4) begin
        @(negedge clka);
        k++;
      end
      if (!dp_if.dp_check) begin
        report_fail("dp_check_wait", "no dp_check pulse within 4 cycles of the guess");
      end else if (plan != P_TMO) begin
        k = (plan == P_EXP) ? TMO : $urandom_range(1, 6);
        repeat (k - 1) @(negedge clka);
        dp_if.dp_done = 1'b1;
        dp_if.dp_ok   = (plan != P_BAD);
        dp_if.dp_new  = (plan == P_NEW || plan == P_EXP);
        @(negedge clka);
        dp_if.dp_done = 1'b0;
        dp_if.dp_ok   = 1'($urandom);
        dp_if.dp_new  = 1'($urandom);
      end
    end
    k = 0;
    while (!(int'(state) == ST_PLAY || int'(state) == ST_FIN || int'(state) == ST_LOST) &&
           k < TMO + 6) begin
      @(negedge clka);
      k++;
    end
    if (k >= TMO + 6) report_fail("resolve_wait", "guess never resolved");
  endtask

  // Monitor: checks every cell command and every guess resolution against the queues.
  initial begin
    cmd_t    c;
    status_t s;
    int      cur;
    bit      resolved;
    forever begin
      @(posedge clka);
      #1;
      cur = int'(state);
      if (dp_if.cell_we === 1'b1) begin
        if (cmd_q.size() == 0) begin
          report_fail("cmd_extra", $sformatf("unexpected cell command idx=%0d reveal=%0d",
                      dp_if.cell_idx, dp_if.cell_reveal));
        end else begin
          c = cmd_q.pop_front();
          checkOutput("cmd_reveal", int'(dp_if.cell_reveal), int'(c.reveal));
          checkOutput("cmd_idx", int'(dp_if.cell_idx), c.idx);
        end
      end
      if (cur == ST_GUESS) saw_chk = 1'b0;
      if (dp_if.dp_check === 1'b1) saw_chk = 1'b1;
      resolved = (mon_prev == ST_GUESS || mon_prev == ST_CHECK) &&
                 !(cur == ST_GUESS || cur == ST_CHECK);
      if (resolved) begin
        if (stat_q.size() == 0) begin
          report_fail("res_extra", $sformatf("unexpected guess resolution to state %0d", cur));
        end else begin
          s = stat_q.pop_front();
          checkOutput("res_state", cur, s.st);
          checkOutput("res_strikes", int'(strikes), s.strikes);
          checkOutput("res_filled", int'(filled), s.filled);
          checkOutput("res_err", int'(err), int'(s.e_err));
          checkOutput("res_won", int'(won), int'(s.st == ST_FIN));
          checkOutput("res_lost", int'(lost), int'(s.st == ST_LOST));
          checkOutput("res_dp_check", int'(saw_chk), int'(s.chk));
          checkOutput("res_row", int'(dp_if.guess_row), s.row);
          checkOutput("res_col", int'(dp_if.guess_col), s.col);
          checkOutput("res_val", int'(dp_if.guess_val), s.val);
        end
      end else if (err === 1'b1) begin
        report_fail("err_spurious", $sformatf("err high in state %0d", cur));
      end
      mon_prev = cur;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   pick, k;
    cmd_t c;
    restart = 1'b1;
    enter = 1'b0;
    difficulty = '0;
    row_in = '0;
    col_in = '0;
    val_in = '0;
    dp_if.dp_done = 1'b0;
    dp_if.dp_ok = 1'b0;
    dp_if.dp_new = 1'b0;
    tick(3);
    checkOutput("rst_state", int'(state), ST_IDLE);
    checkOutput("rst_filled", int'(filled), 0);
    checkOutput("rst_strikes", int'(strikes), 0);
    checkOutput("rst_cell_we", int'(dp_if.cell_we), 0);
    checkOutput("rst_won_lost", int'({won, lost, err}), 0);
    checkOutput("rst_dp_check", int'(dp_if.dp_check), 0);
    checkOutput("rst_guess_val", int'(dp_if.guess_val), 0);
    @(negedge clka);
    restart = 1'b0;
    tick(2);
    checkOutput("idle_stays", int'(state), ST_IDLE);

    new_game(0, 1'b1, 1'b0);

    @(negedge clka);
    dp_if.dp_done = 1'b1;
    dp_if.dp_ok = 1'b0;
    @(negedge clka);
    dp_if.dp_done = 1'b0;
    tick(1);
    checkOutput("stray_done_strikes", int'(strikes), 0);
    checkOutput("stray_done_state", int'(state), ST_PLAY);

    applyStimulus(P_RANGE);
    applyStimulus(P_RANGE);
    applyStimulus(P_TMO);
    applyStimulus(P_EXP);
    while (m_filled < CELLS - 1) begin
      pick = $urandom_range(0, 99);
      if (pick < 60) applyStimulus(P_NEW);
      else if (pick < 75) applyStimulus(P_OLD);
      else if (pick < 85) applyStimulus(P_RANGE);
      else if (pick < 93) applyStimulus(P_TMO);
      else if (m_strikes < MAXS - 1) applyStimulus(P_BAD);
      else applyStimulus(P_NEW);
    end
    applyStimulus(P_OLD);
    checkOutput("filled_15_state", int'(state), ST_PLAY);
    applyStimulus(P_NEW);
    tick(3);
    checkOutput("fin_held", int'(state), ST_FIN);
    checkOutput("won_held", int'(won), 1);
    pulse_enter();
    tick(1);
    checkOutput("fin_exit_state", int'(state), ST_IDLE);
    checkOutput("fin_exit_won", int'(won), 0);

    new_game(3, 1'b0, 1'b1);
    applyStimulus(P_BAD);
    applyStimulus(P_BAD);
    applyStimulus(P_BAD);
    tick(2);
    checkOutput("lost_held", int'(lost), 1);
    pulse_enter();
    tick(1);
    checkOutput("lost_exit_state", int'(state), ST_IDLE);
    checkOutput("lost_exit_lost", int'(lost), 0);

    // Restart in the middle of the prefill walk: the third reveal must never appear.
    for (int i = 0; i < CELLS; i++) begin
      c.reveal = 1'b0;
      c.idx = i;
      cmd_q.push_back(c);
    end
    for (int i = 0; i < 2; i++) begin
      c.reveal = 1'b1;
      c.idx = (i * STEP) % CELLS;
      cmd_q.push_back(c);
    end
    pulse_enter();
    wait_state(ST_SET_DIFF, CELLS + 4, "rp_clear_done");
    @(negedge clka);
    difficulty = 2'd0;
    enter = 1'b1;
    @(negedge clka);
    enter = 1'b0;
    k = 0;
    while (!(int'(state) == ST_PREFILL && int'(dp_if.cell_idx) == STEP % CELLS) && k < 4) begin
      @(negedge clka);
      k++;
    end
    checkOutput("rp_reveal2_idx", int'(dp_if.cell_idx), STEP % CELLS);
    restart = 1'b1;
    @(negedge clka);
    restart = 1'b0;
    checkOutput("rp_state", int'(state), ST_IDLE);
    checkOutput("rp_filled", int'(filled), 0);
    checkOutput("rp_cell_we", int'(dp_if.cell_we), 0);
    dp_if.dp_done = 1'b1;
    dp_if.dp_ok = 1'b0;
    @(negedge clka);
    dp_if.dp_done = 1'b0;
    tick(2);
    checkOutput("late_done_state", int'(state), ST_IDLE);
    checkOutput("late_done_strikes", int'(strikes), 0);

    checkOutput("cmd_queue_left", cmd_q.size(), 0);
    checkOutput("stat_queue_left", stat_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
